// File: rtl/mul_fold_for_743.sv
// mul_fold_for_743: sequential shift-add multiplier for operands < Q.
// A product that reaches 2^OUT_W has the fold constant (a multiple of Q)
// subtracted once, so the result stays congruent to a*b mod Q and fits the
// downstream reducer's OUT_W-bit input.
module mul_fold_for_743 #(
  parameter int Q     = 743,
  parameter int W     = 10,
  parameter int OUT_W = 19,
  parameter int FOLD  = 47552
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int CW = $clog2(W);
  localparam logic [W:0]       Q_C    = (W+1)'(Q);
  localparam logic [OUT_W:0]   FOLD_C = (OUT_W+1)'(FOLD);
  localparam logic [CW-1:0]    CNT_LAST = CW'(W-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FOLD = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [OUT_W:0]  acc_r;
  logic [CW-1:0]   cnt_r;
  logic            err_r;
  // FOLD spans two edges: the first applies the conditional subtraction to
  // acc, the second registers the output so out_data comes straight from flops.
  logic            fold_ph_r;

  logic            accept_s;
  logic [OUT_W:0]  a_ext_s;
  logic [OUT_W:0]  pp_s;
  logic [OUT_W:0]  fold_s;

  // Handshake, partial product and fold arithmetic.
  always_comb begin
    in_ready = (state_r == S_IDLE) && !rst;
    accept_s = in_valid && in_ready;
    a_ext_s  = {{(OUT_W+1-W){1'b0}}, a_r};
    if (b_r[cnt_r]) begin
      pp_s = a_ext_s << cnt_r;
    end else begin
      pp_s = {(OUT_W+1){1'b0}};
    end
    if (acc_r[OUT_W]) begin
      fold_s = acc_r - FOLD_C;
    end else begin
      fold_s = acc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_MUL;
        else          state_s = S_IDLE;
      end
      S_MUL: begin
        if (cnt_r == CNT_LAST) state_s = S_FOLD;
        else                   state_s = S_MUL;
      end
      S_FOLD: begin
        if (fold_ph_r) state_s = S_OUT;
        else           state_s = S_FOLD;
      end
      S_OUT: begin
        if (out_ready) state_s = S_IDLE;
        else           state_s = S_OUT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, shift-add accumulation, fold and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      acc_r     <= {(OUT_W+1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      err_r     <= 1'b0;
      fold_ph_r <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r       <= in_a;
            b_r       <= in_b;
            acc_r     <= {(OUT_W+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            err_r     <= ({1'b0, in_a} >= Q_C) || ({1'b0, in_b} >= Q_C);
            fold_ph_r <= 1'b0;
          end
        end
        S_MUL: begin
          // Runs all W steps even for out-of-range operands to keep latency fixed.
          acc_r <= acc_r + pp_s;
          cnt_r <= cnt_r + CW'(1);
        end
        S_FOLD: begin
          if (!fold_ph_r) begin
            acc_r     <= fold_s;
            fold_ph_r <= 1'b1;
          end else begin
            out_data  <= err_r ? {OUT_W{1'b0}} : acc_r[OUT_W-1:0];
            out_err   <= err_r;
            out_valid <= 1'b1;
            fold_ph_r <= 1'b0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
          end
        end
        default: begin
          fold_ph_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fold_for_743.sv
// Directed self-checking bench for mul_fold_for_743.
module tb_mul_fold_for_743;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_a;
  logic [9:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_data;
  logic        out_err;

  int n_assert;
  int n_fail;

  mul_fold_for_743 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits from just after an accept edge until out_valid is seen on a negedge.
  task automatic wait_result(output int lat, output logic saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk);
      lat++;
    end
  endtask

  // Drives one operand pair, checks latency, result and (if out_ready) consume.
  task automatic run_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                        input logic [18:0] exp_d, input logic exp_e);
    int   lat;
    logic saw_ready;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 10'h3FF;
    in_b = 10'h3FF;
    wait_result(lat, saw_ready);
    check({tag, "_lat"}, lat, 32'd12);
    check({tag, "_busy_ready"}, {31'd0, saw_ready}, 32'd0);
    check({tag, "_data"}, {13'd0, out_data}, {13'd0, exp_d});
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_consumed"}, {30'd0, out_valid, out_err}, 32'd0);
      check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int   lat;
    int   edges;
    logic saw_ready;
    logic ok;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 10'd0;
    in_b      = 10'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {13'd0, out_data}, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Maximum legal product, folded
    run_op("max", 10'd742, 10'd742, 19'd503012, 1'b0);
    // Fold boundary
    run_op("nofold", 10'd706, 10'd742, 19'd523852, 1'b0);
    run_op("fold", 10'd707, 10'd742, 19'd477042, 1'b0);

    // Back-to-back with in_valid held: 0*500 then 100*200
    @(negedge clk);
    in_a = 10'd0;
    in_b = 10'd500;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 10'd100;
    in_b = 10'd200;
    edges = 0;
    ok = 1'b0;
    while (edges < 40) begin
      @(negedge clk);
      if (out_valid && out_data == 19'd0 && !out_err) ok = 1'b1;
      if (in_ready) break;
      @(posedge clk);
      edges++;
    end
    check("b2b_first_data", {31'd0, ok}, 32'd1);
    check("b2b_interval", edges + 1, 32'd14);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, saw_ready);
    check("b2b_lat", lat, 32'd12);
    check("b2b_data", {13'd0, out_data}, 32'd20000);
    @(posedge clk);
    @(negedge clk);

    // Backpressure: hold for 5 cycles, consume on the sixth
    out_ready = 1'b0;
    run_op("bp", 10'd3, 10'd5, 19'd15, 1'b0);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === 19'd15 && in_ready === 1'b0)) ok = 1'b0;
    end
    check("bp_hold", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_consumed", {31'd0, out_valid}, 32'd0);
    check("bp_idle", {31'd0, in_ready}, 32'd1);

    // Out-of-range operand, then a normal op
    run_op("oor", 10'd743, 10'd1, 19'd0, 1'b1);
    run_op("after_oor", 10'd2, 10'd2, 19'd4, 1'b0);

    // Reset during MUL
    @(negedge clk);
    in_a = 10'd742;
    in_b = 10'd742;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready_in_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_output", {31'd0, ok}, 32'd1);
    run_op("after_rst", 10'd1, 10'd1, 19'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
